// File: rtl/irq_latch_ctrl.sv
// irq_latch_ctrl: sequential front end for an external 8-to-3 priority encoder.
// Rising edges on the request lines are latched into a pending register, gated
// by a per-line enable register, and handed to the encoder. The encoder's
// result is presented to a consumer one index at a time over a valid/ack
// handshake. The served pending bit is cleared on acknowledge.
module irq_latch_ctrl #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] irq,
  input  logic         en_we,
  input  logic [N-1:0] en_in,
  output logic [N-1:0] pend_x,
  input  logic [2:0]   enc_y,
  input  logic         enc_f,
  output logic         int_valid,
  output logic [2:0]   int_id,
  input  logic         int_ack,
  output logic [N-1:0] pending
);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t       state;
  logic [N-1:0] irq_q;
  logic [N-1:0] enable;
  logic [N-1:0] rise;
  logic [N-1:0] ack_clr;

  // Rising-edge detect and one-hot clear of the index being acknowledged.
  // The ack only has an effect while a presentation is in progress.
  always_comb begin
    rise = irq & ~irq_q;
    if ((state == PRESENT) && int_ack) begin
      ack_clr = {{(N-1){1'b0}}, 1'b1} << int_id;
    end else begin
      ack_clr = {N{1'b0}};
    end
  end

  // The encoder input depends only on registers, so no loop runs through
  // the encoder.
  assign pend_x = pending & enable;

  // Request history, pending and enable registers. A new edge is ORed in
  // after the clear, so it wins when it hits the line being acknowledged.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q   <= {N{1'b0}};
      pending <= {N{1'b0}};
      enable  <= {N{1'b1}};
    end else begin
      irq_q   <= irq;
      pending <= (pending & ~ack_clr) | rise;
      if (en_we) begin
        enable <= en_in;
      end else begin
        enable <= enable;
      end
    end
  end

  // Handshake FSM with registered valid and id. The FSM samples the encoder
  // only in IDLE, so a presentation cannot be pre-empted or withdrawn.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      int_valid <= 1'b0;
      int_id    <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (enc_f) begin
            int_id    <= enc_y;
            int_valid <= 1'b1;
            state     <= PRESENT;
          end else begin
            int_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        PRESENT: begin
          if (int_ack) begin
            int_valid <= 1'b0;
            state     <= IDLE;
          end else begin
            int_valid <= 1'b1;
            state     <= PRESENT;
          end
        end
        default: begin
          int_valid <= 1'b0;
          int_id    <= 3'd0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_latch_ctrl.sv
// Directed testbench for irq_latch_ctrl. It models the 8-to-3 priority encoder
// and keeps a scoreboard queue of expected grant ids.
module tb_irq_latch_ctrl;

  logic       clk;
  logic       rst;
  logic [7:0] irq;
  logic       en_we;
  logic [7:0] en_in;
  logic [7:0] pend_x;
  logic [2:0] enc_y;
  logic       enc_f;
  logic       int_valid;
  logic [2:0] int_id;
  logic       int_ack;
  logic [7:0] pending;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  irq_latch_ctrl #(.N(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .irq       (irq),
    .en_we     (en_we),
    .en_in     (en_in),
    .pend_x    (pend_x),
    .enc_y     (enc_y),
    .enc_f     (enc_f),
    .int_valid (int_valid),
    .int_id    (int_id),
    .int_ack   (int_ack),
    .pending   (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference priority encoder: highest set bit wins.
  always_comb begin
    enc_f = |pend_x;
    enc_y = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (pend_x[i]) enc_y = 3'(i);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for int_valid, then compare the id against the scoreboard.
  task automatic wait_grant(input string tag, output int waited);
    logic [7:0] exp_id;
    waited = 0;
    while (int_valid !== 1'b1 && waited < 20) begin
      step();
      waited++;
    end
    if (exp_q.size() > 0) exp_id = exp_q.pop_front();
    else exp_id = 8'hEE;
    chk({tag, "_valid"}, {7'd0, int_valid}, 8'd1);
    chk({tag, "_id"}, {5'd0, int_id}, exp_id);
  endtask

  // Wait for a grant, ack it in its first PRESENT cycle and check valid drops.
  task automatic grant_ack(input string tag, output int waited);
    wait_grant(tag, waited);
    int_ack = 1'b1;
    step();
    int_ack = 1'b0;
    chk({tag, "_drop"}, {7'd0, int_valid}, 8'd0);
  endtask

  initial begin
    int w;
    rst = 1'b1; irq = 8'h00; en_we = 1'b0; en_in = 8'h00; int_ack = 1'b0;
    step();
    step();
    chk("rst_pending", pending, 8'h00);
    chk("rst_valid", {7'd0, int_valid}, 8'd0);
    chk("rst_id", {5'd0, int_id}, 8'd0);
    chk("rst_pend_x", pend_x, 8'h00);

    // Single request with two-edge latency, no re-grant while held high.
    rst = 1'b0;
    irq = 8'h10;
    step();
    chk("single_pending", pending, 8'h10);
    chk("single_nolat", {7'd0, int_valid}, 8'd0);
    exp_q.push_back(8'd4);
    step();
    wait_grant("single", w);
    chk("single_latency", 8'(w), 8'd0);
    int_ack = 1'b1;
    step();
    int_ack = 1'b0;
    chk("single_ack_pending", pending, 8'h00);
    chk("single_ack_valid", {7'd0, int_valid}, 8'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("single_noregrant", {7'd0, int_valid}, 8'd0);
    end
    irq = 8'h00;
    step();

    // Ack while idle is ignored.
    int_ack = 1'b1;
    step();
    int_ack = 1'b0;
    chk("idle_ack_valid", {7'd0, int_valid}, 8'd0);
    chk("idle_ack_pending", pending, 8'h00);

    // Priority order 7, 2, 0 with one idle cycle between grants.
    irq = 8'h85;
    step();
    irq = 8'h00;
    chk("prio_pending", pending, 8'h85);
    exp_q.push_back(8'd7);
    exp_q.push_back(8'd2);
    exp_q.push_back(8'd0);
    grant_ack("prio7", w);
    chk("prio7_wait", 8'(w), 8'd1);
    grant_ack("prio2", w);
    chk("prio2_gap", 8'(w), 8'd1);
    grant_ack("prio0", w);
    chk("prio0_gap", 8'(w), 8'd1);
    chk("prio_pending_end", pending, 8'h00);

    // Masking: disabled line accumulates but is invisible until enabled.
    en_we = 1'b1; en_in = 8'h7F;
    step();
    en_we = 1'b0;
    irq = 8'h80;
    step();
    irq = 8'h00;
    chk("mask_pending", pending, 8'h80);
    chk("mask_pend_x", pend_x, 8'h00);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mask_novalid", {7'd0, int_valid}, 8'd0);
    end
    en_we = 1'b1; en_in = 8'hFF;
    step();
    en_we = 1'b0;
    chk("mask_pend_x_on", pend_x, 8'h80);
    exp_q.push_back(8'd7);
    grant_ack("mask", w);

    // Hold and no preemption: id 2 held over a delayed ack while line 6 rises.
    irq = 8'h04;
    step();
    irq = 8'h00;
    exp_q.push_back(8'd2);
    wait_grant("hold", w);
    for (int i = 0; i < 5; i++) begin
      irq = (i == 1) ? 8'h40 : 8'h00;
      step();
      chk("hold_valid", {7'd0, int_valid}, 8'd1);
      chk("hold_id", {5'd0, int_id}, 8'd2);
    end
    irq = 8'h00;
    int_ack = 1'b1;
    step();
    int_ack = 1'b0;
    chk("hold_pending", pending, 8'h40);
    exp_q.push_back(8'd6);
    grant_ack("preempt", w);

    // Simultaneous set and clear on line 3: set wins.
    irq = 8'h08;
    step();
    irq = 8'h00;
    exp_q.push_back(8'd3);
    wait_grant("sc1", w);
    irq = 8'h08; int_ack = 1'b1;
    step();
    irq = 8'h00; int_ack = 1'b0;
    chk("sc_pending", pending, 8'h08);
    chk("sc_valid", {7'd0, int_valid}, 8'd0);
    exp_q.push_back(8'd3);
    grant_ack("sc2", w);
    chk("sc_pending_end", pending, 8'h00);

    // Reset during PRESENT with pending = 0C.
    irq = 8'h0C;
    step();
    irq = 8'h00;
    exp_q.push_back(8'd3);
    wait_grant("rmid", w);
    chk("rmid_pending_pre", pending, 8'h0C);
    en_we = 1'b1; en_in = 8'h00;
    step();
    en_we = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rmid_valid", {7'd0, int_valid}, 8'd0);
    chk("rmid_pending", pending, 8'h00);
    chk("rmid_id", {5'd0, int_id}, 8'd0);
    irq = 8'h01;
    step();
    chk("rmid_enable", pend_x, 8'h01);
    exp_q.push_back(8'd0);
    grant_ack("rmid_after", w);
    irq = 8'h00;
    step();
    chk("queue_empty", 8'(exp_q.size()), 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/irq_latch_ctrl.md
# irq_latch_ctrl

Sequential front end for the 8-to-3 priority encoder. It captures rising edges on eight request lines into a pending register and gates them with a per-line enable register. It drives the gated vector into the encoder's `x` input and takes the encoder's `y`/`f` results back. A valid/ack handshake presents one request index at a time to the consumer and clears the served pending bit on acknowledge.

## Interface
- `N`, 8, number of request lines; fixed at 8 to match the encoder width.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `irq`  in  8  request lines, synchronous to `clk`; rising edge = new request.
- `en_we`  in  1  enable-register write strobe.
- `en_in`  in  8  enable-register write data; bit i = 1 enables line i.
- `pend_x`  out  8  `pending & enable`, combinational; drives the encoder `x`.
- `enc_y`  in  3  encoder `y`, the index of the highest set bit of `pend_x`.
- `enc_f`  in  1  encoder `f`; 1 when `pend_x` is nonzero.
- `int_valid`  out  1  a request index is being presented.
- `int_id`  out  3  the presented index; stable while `int_valid` = 1.
- `int_ack`  in  1  consumer accepts `int_id`; sampled only while `int_valid` = 1.
- `pending`  out  8  raw pending register, for status and debug.

## Operation
- **Edge detect:** `irq_q` is a registered copy of `irq`. Each cycle, `rise = irq & ~irq_q`. A set `rise` bit sets the matching `pending` bit regardless of `enable`.
- **Masking:** disabled lines still accumulate in `pending`; they only become visible in `pend_x` once enabled. An `en_we` write takes effect on the next edge.
- **Priority:** the encoder decides priority. Bit 7 is highest, bit 0 lowest. This block uses `enc_y` only when `enc_f` = 1.
- **FSM:** two states, IDLE and PRESENT.
  - In IDLE, if `enc_f` = 1: `int_id` <= `enc_y`, `int_valid` <= 1, go to PRESENT. Otherwise stay in IDLE.
  - In PRESENT, `int_id` is held. On `int_ack` = 1: clear `pending[int_id]`, `int_valid` <= 0, go to IDLE. Otherwise stay.
- **Same-bit set and clear:** if a rising edge on line `int_id` coincides with the ack cycle, the set wins and the bit stays pending.
- **Other bits:** bits other than `int_id` follow normal set rules during an ack cycle.
- **Ack outside PRESENT:** `int_ack` in IDLE is ignored and has no side effects.
- **Mask change in PRESENT:** clearing `enable[int_id]` while in PRESENT does not withdraw the presentation. The handshake completes normally.
- **No preemption:** a higher-priority request arriving in PRESENT waits until the next IDLE cycle.

## Timing
- **Reset values:**
  - `pending` = 8'h00, `irq_q` = 8'h00, enable register = 8'hFF.
  - `int_valid` = 0, `int_id` = 3'b000, FSM = IDLE.
  - As a result, `pend_x` = 8'h00.
- **Reset mid-handshake:** reset in PRESENT drops `int_valid` on the next edge and loses all pending requests.
- **Line high at reset release:** because `irq_q` resets to 0, a line held high across reset release registers as one rising edge on the first post-reset cycle.
- **Latency from request:** `irq[i]` rises before edge k → `pending[i]` = 1 after edge k → `pend_x` and encoder settle combinationally → `int_valid` = 1 after edge k+1. Total: 2 edges.
- **Back-to-back grants:** ack sampled at edge m → `int_valid` = 0 after edge m. The next grant asserts after edge m+1 at the earliest. Minimum one idle cycle between grants.
- **Throughput:** at most one grant per 2 cycles, with the consumer acking in the first PRESENT cycle.
- **Combinational paths:** `pend_x` depends only on registers, so there is no loop through the encoder. `enc_y`/`enc_f` feed only flop inputs.

## Test plan
- **Single request:** reset, then `irq` = 8'h10 held. Require `int_valid` = 1 and `int_id` = 3'd4 two edges later. Ack one cycle → `pending` = 8'h00, `int_valid` = 0; no re-grant while `irq` stays high.
- **Priority order:** pulse `irq` = 8'h85 in one cycle, ack each grant immediately. Require grants in order 7, 2, 0 with one idle cycle between grants, then `pending` = 8'h00.
- **Masking:** `en_in` = 8'h7F with `en_we`, then pulse `irq[7]`. Require `pending` = 8'h80, `pend_x` = 8'h00, no `int_valid`. Write `en_in` = 8'hFF → grant with `int_id` = 7 follows.
- **Hold and preemption:** in PRESENT with id 2, delay ack 5 cycles and raise `irq[6]` meanwhile. Require `int_id` stable at 2. After the ack, the next grant is 6.
- **Simultaneous set/clear:** a new rising edge on line 3 in the same cycle as the ack of id 3. Require `pending[3]` = 1 afterward and a second grant of id 3.
- **Reset mid-handshake:** assert `rst` during PRESENT with `pending` = 8'h0C. Require `int_valid` = 0, `pending` = 8'h00, and enable = 8'hFF after the edge.
